// File: rtl/riscv_multicycle_ctrl.sv
// Moore sequencer for the shared-memory multicycle RV32I datapath (lw, sw, R, I-ALU, beq, jal).
// Optional macro RISCV_ILLEGAL_TRAP_EN: unrecognised opcodes park the FSM in an absorbing Trap state.
module riscv_multicycle_ctrl #(
    parameter int MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_FUNCT = 2'd2
    } alu_op_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    alu_op_t    alu_op;
    logic       pcw, irw, memw, regw;
    logic       last_wait;

    assign last_wait = (cnt_q == LAT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = 4'd0;
        alu_op    = OP_ADD;
        pcw       = 1'b0;
        irw       = 1'b0;
        memw      = 1'b0;
        regw      = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (last_wait) begin
                    pcw     = 1'b1;
                    irw     = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011,
                    7'b0100011: state_d = S_MEMADR;
                    7'b0110011: state_d = S_EXECR;
                    7'b0010011: state_d = S_EXECI;
                    7'b1101111: state_d = S_JAL;
                    7'b1100011: state_d = S_BEQ;
`ifdef RISCV_ILLEGAL_TRAP_EN
                    default:    state_d = S_TRAP;
`else
                    default:    state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (last_wait) state_d = S_MEMWB;
                else           cnt_d   = cnt_q + 4'd1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                // single strobe per store, on the cycle the memory completes
                if (last_wait) begin
                    memw    = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = OP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = OP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regw    = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw     = 1'b1;
                state_d = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = OP_SUB;
                pcw     = Zero;
                state_d = S_FETCH;
            end
`ifdef RISCV_ILLEGAL_TRAP_EN
            S_TRAP:  state_d = S_TRAP;
`else
            S_TRAP:  state_d = S_FETCH;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            OP_SUB: ALUControl = 3'b001;
            OP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

    // write enables are held off combinationally for the whole time reset is asserted
    assign PCWrite  = pcw  & reset;
    assign IRWrite  = irw  & reset;
    assign MemWrite = memw & reset;
    assign RegWrite = regw & reset;
    assign State    = state_q;

endmodule
